video_stream_src: RTL

//  Parametrised AXI4-Stream video source, replacing fixed 640x480 RGB444 pixel generation into the HDMI block design.

---
 rtl/video_stream_src_pkg.sv | 28 ++
 rtl/video_stream_src_axis_skid_buf.sv | 55 +++++
 rtl/video_stream_src.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_src_pkg.sv
// Shared types and constants for the video stream source: pattern modes, raster defaults
// and the full-scale colour bar table.
package video_stream_src_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } pattern_mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Index 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_TABLE = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                              BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};

endpackage

// File: rtl/video_stream_src_axis_skid_buf.sv
// Two-entry AXI-Stream buffer; the output word is a register and stays put until popped.
module axis_skid_buf #(
    parameter int WIDTH = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign s_ready_o = (cnt_q != 2'd2);
    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;
    assign push      = s_valid_i & s_ready_o;
    assign pop       = m_valid_o & m_ready_i;

    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= s_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/video_stream_src.sv
// AXI-Stream video source: raster walk, pattern/external pixel fetch, depth expansion, skid output.
// Optional VSS_FRAME_SCROLL_EN adds frame_cnt and scrolls the colour bars by frame_cnt[7:0].
module video_stream_src
    import video_stream_src_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int IN_BPC     = 4,
    parameter int OUT_BPC    = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                          pixel_clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [3*IN_BPC-1:0]           solid_rgb,
    output logic                          req_valid,
    output logic [$clog2(H_ACTIVE)-1:0]   req_x,
    output logic [$clog2(V_ACTIVE)-1:0]   req_y,
    input  logic [3*IN_BPC-1:0]           rgb_in,
    output logic [3*OUT_BPC-1:0]          tdata,
    output logic                          tvalid,
    output logic                          tuser,
    output logic                          tlast,
    input  logic                          tready,
    output logic                          busy
`ifdef VSS_FRAME_SCROLL_EN
    ,output logic [15:0]                  frame_cnt
`endif
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int TW = 3 * OUT_BPC;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [TW-1:0] expand_rgb(input logic [3*IN_BPC-1:0] c);
        logic [TW-1:0] r;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < OUT_BPC; i++)
                r[k*OUT_BPC + i] = c[k*IN_BPC + (IN_BPC - 1 - ((OUT_BPC - 1 - i) % IN_BPC))];
        return r;
    endfunction

    function automatic logic [TW-1:0] full_scale(input logic [23:0] c);
        return {{OUT_BPC{c[23]}}, {OUT_BPC{c[15]}}, {OUT_BPC{c[7]}}};
    endfunction

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int;
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic [0:0]    state_q, state_d;
    pattern_mode_e mode_q, mode_d;
    logic [XW-1:0] x_q, x_d, s1_x_q;
    logic [YW-1:0] y_q, y_d, s1_y_q;
    logic          done_q, done_d;
    logic          s1_vld_q, s1_vld_d;
    logic [1:0]    skid_cnt;
    logic          skid_rdy;
    logic [2:0]    occ;
    logic          pop, issue, final_acc;
    logic [TW+1:0] skid_out;
    logic [TW-1:0] s1_pix;
    logic          s1_user, s1_last;
    logic [7:0]    scroll;
    logic [31:0]   bar_x;
    logic [2:0]    bar_idx;
    logic          chk;

    // Credit: skid entries plus the S1 beat in flight, minus a beat leaving this cycle.
    assign pop       = tvalid & tready;
    assign occ       = {1'b0, skid_cnt} + {2'b00, s1_vld_q};
    assign issue     = (state_q == ST_RUN) && !done_q && (occ <= 3'd1 + {2'b00, pop});
    assign final_acc = pop & tlast & done_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                    mode_d  = pattern_mode_e'(mode);
                    x_d     = '0;
                    y_d     = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                if (issue) begin
                    if (x_q == XW'(H_ACTIVE - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(V_ACTIVE - 1)) begin
                            y_d    = '0;
                            done_d = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                if (final_acc) begin
                    if (en) begin
                        mode_d = pattern_mode_e'(mode);
                        done_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    assign s1_vld_d = issue | (s1_vld_q & ~skid_rdy);

    always_ff @(posedge pixel_clk or posedge rst_int) begin
        if (rst_int) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_EXT;
            x_q      <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            x_q      <= x_d;
            y_q      <= y_d;
            done_q   <= done_d;
            s1_vld_q <= s1_vld_d;
            if (issue) begin
                s1_x_q <= x_q;
                s1_y_q <= y_q;
            end
        end
    end

`ifdef VSS_FRAME_SCROLL_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge pixel_clk or posedge rst_int) begin
        if (rst_int)        frame_cnt_q <= '0;
        else if (final_acc) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_cnt = frame_cnt_q;
    assign scroll    = frame_cnt_q[7:0];
`else
    assign scroll = '0;
`endif

    // S1: pixel for the coordinate issued last cycle; rgb_in belongs to it in EXT mode.
    always_comb begin
        bar_x   = (32'(s1_x_q) + 32'(scroll)) % 32'(H_ACTIVE);
        bar_idx = 3'(bar_x / 32'(H_ACTIVE / 8));
        chk     = 1'((32'(s1_x_q) >> CHECK_LOG2) ^ (32'(s1_y_q) >> CHECK_LOG2));
        s1_pix  = '0;
        case (mode_q)
            MODE_EXT:   s1_pix = expand_rgb(rgb_in);
            MODE_BARS:  s1_pix = full_scale(BAR_TABLE[bar_idx]);
            MODE_CHECK: s1_pix = chk ? '0 : '1;
            MODE_SOLID: s1_pix = expand_rgb(solid_rgb);
            default:    s1_pix = '0;
        endcase
    end

    assign s1_user = (s1_x_q == '0) && (s1_y_q == '0);
    assign s1_last = (s1_x_q == XW'(H_ACTIVE - 1));

    axis_skid_buf #(.WIDTH(TW + 2)) u_skid (
        .clk_i     (pixel_clk),
        .rst_i     (rst_int),
        .s_valid_i (s1_vld_q),
        .s_data_i  ({s1_user, s1_last, s1_pix}),
        .s_ready_o (skid_rdy),
        .m_valid_o (tvalid),
        .m_data_o  (skid_out),
        .m_ready_i (tready),
        .count_o   (skid_cnt)
    );

    assign tuser     = skid_out[TW+1];
    assign tlast     = skid_out[TW];
    assign tdata     = skid_out[TW-1:0];
    assign req_valid = issue && (mode_q == MODE_EXT);
    assign req_x     = x_q;
    assign req_y     = y_q;
    assign busy      = (state_q == ST_RUN);

endmodule
